// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if
// Bundles the datapath-facing signals of the multi-cycle MIPS controller.
//   slave  : controller side (takes opcode/flags/handshake, drives strobes)
//   master : datapath/environment side (drives opcode/flags/handshake)
// Signals:
//   Op_i, Zero_i, MemReady_i           - opcode, ALU zero flag, memory ready
//   PCWrite_o .. PCSource_o            - datapath control strobes and selects
//   Illegal_o, State_o, InstCnt_o      - debug/status outputs
interface multicycle_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       Op_i;
  logic             Zero_i;
  logic             MemReady_i;
  logic             PCWrite_o;
  logic             PCWriteCond_o;
  logic             IorD_o;
  logic             MemRead_o;
  logic             MemWrite_o;
  logic             IRWrite_o;
  logic             MemtoReg_o;
  logic             RegDst_o;
  logic             RegWrite_o;
  logic             ALUSrcA_o;
  logic [1:0]       ALUSrcB_o;
  logic [1:0]       ALUOp_o;
  logic [1:0]       PCSource_o;
  logic             Illegal_o;
  logic [3:0]       State_o;
  logic [CNT_W-1:0] InstCnt_o;

  modport slave (
    input  Op_i, Zero_i, MemReady_i,
    output PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o,
           IRWrite_o, MemtoReg_o, RegDst_o, RegWrite_o, ALUSrcA_o,
           ALUSrcB_o, ALUOp_o, PCSource_o, Illegal_o, State_o, InstCnt_o
  );

  modport master (
    output Op_i, Zero_i, MemReady_i,
    input  PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o,
           IRWrite_o, MemtoReg_o, RegDst_o, RegWrite_o, ALUSrcA_o,
           ALUSrcB_o, ALUOp_o, PCSource_o, Illegal_o, State_o, InstCnt_o
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
// Control FSM for a multi-cycle MIPS datapath (R-type, addi, lw, sw, beq, j).
// Memory accesses wait on MemReady_i; a retired-instruction counter is kept.
// Ports:
//   clk_i  - clock, rising edge
//   rst_i  - asynchronous active-low reset
//   bus    - multicycle_ctrl_if.slave: opcode/flags in, control strobes out
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  multicycle_ctrl_if.slave  bus
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    RWB    = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9,
    ADDIEX = 4'd10,
    ADDIWB = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t           state, next_state;
  logic [CNT_W-1:0] inst_cnt;
  logic             retire;

  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       memto_reg, reg_dst, reg_write, alu_src_a, illegal;
  logic [1:0] alu_src_b, alu_op, pc_source;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= FETCH;
    else        state <= next_state;
  end

  // Retire pulse comes from the last state of each instruction; counter wraps.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)      inst_cnt <= '0;
    else if (retire) inst_cnt <= inst_cnt + CNT_W'(1);
  end

  always_comb begin
    next_state    = FETCH;
    retire        = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    memto_reg     = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    illegal       = 1'b0;
    unique case (state)
      FETCH: begin
        // PC+4 is computed every fetch cycle but only committed with the IR.
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = bus.MemReady_i;
        pc_write  = bus.MemReady_i;
        next_state = bus.MemReady_i ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        case (bus.Op_i)
          OP_RTYPE:      next_state = EXEC;
          OP_ADDI:       next_state = ADDIEX;
          OP_LW, OP_SW:  next_state = MEMADR;
          OP_BEQ:        next_state = BRANCH;
          OP_J:          next_state = JUMP;
          default: begin
            illegal    = 1'b1;
            next_state = FETCH;
          end
        endcase
      end
      MEMADR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        next_state = (bus.Op_i == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        mem_read   = 1'b1;
        iord       = 1'b1;
        next_state = bus.MemReady_i ? MEMWB : MEMRD;
      end
      MEMWB: begin
        reg_write = 1'b1;
        memto_reg = 1'b1;
        retire    = 1'b1;
      end
      MEMWR: begin
        mem_write  = 1'b1;
        iord       = 1'b1;
        retire     = bus.MemReady_i;
        next_state = bus.MemReady_i ? FETCH : MEMWR;
      end
      EXEC: begin
        alu_src_a  = 1'b1;
        alu_op     = 2'b10;
        next_state = RWB;
      end
      RWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire    = 1'b1;
      end
      ADDIEX: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        next_state = ADDIWB;
      end
      ADDIWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        retire        = 1'b1;
      end
      JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        retire    = 1'b1;
      end
      default: next_state = FETCH;
    endcase
  end

  // Strobes are gated by reset directly so they drop without a clock edge.
  assign bus.PCWrite_o     = rst_i & pc_write;
  assign bus.PCWriteCond_o = rst_i & pc_write_cond;
  assign bus.IorD_o        = rst_i & iord;
  assign bus.MemRead_o     = rst_i & mem_read;
  assign bus.MemWrite_o    = rst_i & mem_write;
  assign bus.IRWrite_o     = rst_i & ir_write;
  assign bus.MemtoReg_o    = rst_i & memto_reg;
  assign bus.RegDst_o      = rst_i & reg_dst;
  assign bus.RegWrite_o    = rst_i & reg_write;
  assign bus.ALUSrcA_o     = rst_i & alu_src_a;
  assign bus.ALUSrcB_o     = rst_i ? alu_src_b : 2'b00;
  assign bus.ALUOp_o       = rst_i ? alu_op    : 2'b00;
  assign bus.PCSource_o    = rst_i ? pc_source : 2'b00;
  assign bus.Illegal_o     = rst_i & illegal;
  assign bus.State_o       = state;
  assign bus.InstCnt_o     = inst_cnt;

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle MIPS control FSM. It sequences the shared datapath (one ALU, one unified memory, IR/MDR/A/B/ALUOut registers) through fetch, decode, execute, memory and writeback. It supports R-type, addi, lw, sw, beq and j. Memory has variable latency and is handled by a ready handshake. A retired-instruction counter is provided for test and debug.

Parameters:
CNT_W, 32, width of retired-instruction counter InstCnt_o

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  reset, asynchronous, active-low
Op_i  in  6  opcode field of IR (IR[31:26])
Zero_i  in  1  ALU zero flag
MemReady_i  in  1  memory access completes this cycle
PCWrite_o  out  1  unconditional PC load
PCWriteCond_o  out  1  PC load if Zero_i
IorD_o  out  1  memory address select: 0 = PC, 1 = ALUOut
MemRead_o  out  1  memory read request
MemWrite_o  out  1  memory write request
IRWrite_o  out  1  IR load
MemtoReg_o  out  1  writeback data: 0 = ALUOut, 1 = MDR
RegDst_o  out  1  dest reg: 0 = rt, 1 = rd
RegWrite_o  out  1  register file write
ALUSrcA_o  out  1  ALU A: 0 = PC, 1 = A reg
ALUSrcB_o  out  2  ALU B: 00 = B, 01 = 4, 10 = signext imm, 11 = signext imm<<2
ALUOp_o  out  2  00 = add, 01 = sub, 10 = use funct
PCSource_o  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
Illegal_o  out  1  one-cycle pulse on unknown opcode
State_o  out  4  current state encoding
InstCnt_o  out  CNT_W  retired instructions

Behaviour:
- Reset (rst_i low, async):
  - state = FETCH(0), InstCnt_o = 0.
  - All 1-bit strobes, the 2-bit selects and Illegal_o are forced to 0 while reset is held.
  - The first fetch request is issued in the first cycle after deassertion.
- Unused selects are driven to 0 in every state. No x outputs.
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RWB 7, BRANCH 8, JUMP 9, ADDIEX 10, ADDIWB 11. Values 12-15 are unreachable and go to FETCH.
- FETCH:
  - Outputs: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite and PCWrite are asserted only in the cycle MemReady_i=1 (Mealy). Then -> DECODE; otherwise hold FETCH with MemRead held high.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut). Next state by Op_i:
  - 000000 -> EXEC
  - 001000 -> ADDIEX
  - 100011 / 101011 -> MEMADR
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - other -> Illegal_o=1 for this cycle, -> FETCH; instruction not counted.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. lw -> MEMRD, sw -> MEMWR. Op_i is held stable by the IR.
- MEMRD: MemRead=1, IorD=1. Waits for MemReady_i, then -> MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. -> FETCH; retire.
- MEMWR: MemWrite=1, IorD=1. Waits for MemReady_i, then -> FETCH; retire in the ready cycle.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. -> RWB.
- RWB: RegWrite=1, RegDst=1, MemtoReg=0. -> FETCH; retire.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. -> ADDIWB.
- ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0. -> FETCH; retire.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. -> FETCH; retire whether taken or not.
- JUMP: PCWrite=1, PCSource=10. -> FETCH; retire.
- Latency in cycles with zero-wait memory:
  - lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
  - Each memory wait cycle adds one cycle.
- Counter behaviour:
  - InstCnt_o increments by 1 on the retire edge and wraps modulo 2^CNT_W.
  - Saturation is not applied.
- MemReady_i is ignored in all non-memory states.
- Reset asserted mid-instruction aborts it: no retire, state -> FETCH immediately, outputs go to 0 asynchronously.

Test Plan:
- Reset then release with MemReady_i=1, Op_i=000000 -> states 0,1,6,7,0. RegWrite=1 and RegDst=1 only in state 7. InstCnt_o=1 after 4 cycles.
- lw (100011) with MemReady_i low 2 cycles in FETCH and 3 cycles in MEMRD -> IRWrite/PCWrite single pulse on the ready cycle. MemRead held continuously through each wait. Total 10 cycles. MemtoReg=1 in MEMWB.
- sw (101011), zero wait -> MemWrite=1 and IorD=1 for exactly 1 cycle in state 5. RegWrite never asserted. 4 cycles total.
- beq (000100) with Zero_i=1, then again with Zero_i=0 -> PCWriteCond=1, ALUOp=01, PCSource=01 in state 8 both times. InstCnt_o advances by 2.
- Op_i=111111 -> Illegal_o pulses 1 cycle in DECODE. Returns to FETCH. InstCnt_o unchanged. No RegWrite/MemWrite.
- Reset asserted in MEMRD mid-wait -> outputs go to 0 without a clock edge, State_o=0, InstCnt_o=0. Count preset to 2^CNT_W-1 (CNT_W=4: 15) then one j retires -> InstCnt_o=0.
